fpga_top: RTL and testbench

FPGA_TOP -- requirements
Module: fpga_top

---
 rtl/fpga_pkg.sv | 50 +++++
 rtl/fpga_lb.sv | 33 +++
 rtl/fpga_top.sv | 141 ++++++++++++++
 tb/tb_fpga_top.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// Shared configuration field layout and encodings for the fpga_top routing fabric.
package fpga_pkg;

  localparam int unsigned CODE_W       = 2;
  localparam int unsigned CFG_TRK_BITS = 12;
  localparam int unsigned CB_SIDES     = 6;
  localparam int unsigned LB_CFG_BITS  = 5;
  localparam int unsigned LB_SYNC_BIT  = 4;
  localparam int unsigned SB_PAIRS     = 6;

  localparam int unsigned SIDE_N = 0;
  localparam int unsigned SIDE_E = 1;
  localparam int unsigned SIDE_S = 2;
  localparam int unsigned SIDE_W = 3;

  localparam int unsigned LBS_BOTTOM = 0;
  localparam int unsigned LBS_RIGHT  = 1;
  localparam int unsigned LBS_TOP    = 2;
  localparam int unsigned LBS_LEFT   = 3;
  localparam int unsigned LBS_USED   = 4;

  localparam int unsigned PIN_A = 0;
  localparam int unsigned PIN_B = 1;
  localparam int unsigned PIN_Y = 2;

  // Field value 2'b01 drives the first/inner end, 2'b10 the second/outer end.
  typedef enum logic [1:0] {
    CODE_OFF  = 2'b00,
    CODE_FWD  = 2'b01,
    CODE_REV  = 2'b10,
    CODE_BOTH = 2'b11
  } code_e;

  function automatic int unsigned pair_first(input int unsigned p);
    case (p)
      0, 1, 3: return SIDE_N;
      2:       return SIDE_W;
      default: return SIDE_E;
    endcase
  endfunction

  function automatic int unsigned pair_second(input int unsigned p);
    case (p)
      0:       return SIDE_E;
      3, 5:    return SIDE_W;
      default: return SIDE_S;
    endcase
  endfunction

endpackage

// File: rtl/fpga_lb.sv
// Logic block: 2-input LUT with an optional output register.
module fpga_lb
  import fpga_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_i,
  input  logic                   b_i,
  input  logic [LB_CFG_BITS-1:0] cfg_i,
  output logic                   y_o
);

  logic [3:0] truth;
  logic       y_d;
  logic       y_q;

  assign truth = cfg_i[3:0];

  always_comb begin
    y_d = truth[{b_i, a_i}];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = cfg_i[LB_SYNC_BIT] ? y_q : y_d;

endmodule

// File: rtl/fpga_top.sv
// Island-style FPGA fabric: switch boxes, connection boxes, pads and logic blocks on shared tristate segments.
module fpga_top
  import fpga_pkg::*;
#(
  parameter int unsigned W = 3,
  parameter int unsigned R = 5,
  parameter int unsigned C = 5
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [R*C*W*CFG_TRK_BITS-1:0]              brbselect,
  input  logic [(R-1)*(C-1)*W*W*CFG_TRK_BITS-1:0]    bsbselect,
  input  logic [(R-1)*(C-1)*LB_CFG_BITS-1:0]         lbselect,
  input  logic [R*W*CODE_W-1:0]                      leftioselect,
  input  logic [R*W*CODE_W-1:0]                      rightioselect,
  input  logic [C*W*CODE_W-1:0]                      topioselect,
  input  logic [C*W*CODE_W-1:0]                      bottomioselect,
  inout  tri logic [R-1:0]                           left,
  inout  tri logic [R-1:0]                           right,
  inout  tri logic [C-1:0]                           top,
  inout  tri logic [C-1:0]                           bottom
);

  localparam int unsigned NH         = R * (C + 1) * W;
  localparam int unsigned NV         = (R + 1) * C * W;
  localparam int unsigned PIN_STRIDE = W * CFG_TRK_BITS;
  localparam int unsigned LB_STRIDE  = W * W * CFG_TRK_BITS;

  // Horizontal segment k of a row lies west of node column k (k = C is the east edge);
  // vertical segment k of a column lies south of node row k (k = R is the north edge).
  tri logic [NH+NV-1:0] seg;
  logic                 cfg_rsvd_unused;

  function automatic int unsigned hidx(input int unsigned row, input int unsigned k,
                                       input int unsigned t);
    return (row * (C + 1) + k) * W + t;
  endfunction

  function automatic int unsigned vidx(input int unsigned k, input int unsigned col,
                                       input int unsigned t);
    return NH + (k * C + col) * W + t;
  endfunction

  function automatic int unsigned node_side(input int unsigned row, input int unsigned col,
                                            input int unsigned side, input int unsigned t);
    case (side)
      SIDE_N:  return vidx(row + 1, col, t);
      SIDE_E:  return hidx(row, col + 1, t);
      SIDE_S:  return vidx(row, col, t);
      default: return hidx(row, col, t);
    endcase
  endfunction

  function automatic int unsigned lb_side(input int unsigned row, input int unsigned col,
                                          input int unsigned side, input int unsigned t);
    case (side)
      LBS_BOTTOM: return hidx(row, col + 1, t);
      LBS_RIGHT:  return vidx(row + 1, col + 1, t);
      LBS_TOP:    return hidx(row + 1, col + 1, t);
      default:    return vidx(row + 1, col, t);
    endcase
  endfunction

  // Connection-box sides 4-5 are reserved; folding the bus keeps every bit formally consumed.
  assign cfg_rsvd_unused = ^bsbselect;

  for (genvar r = 0; r < R; r++) begin : g_sb_row
    for (genvar c = 0; c < C; c++) begin : g_sb_col
      for (genvar t = 0; t < W; t++) begin : g_sb_trk
        for (genvar p = 0; p < SB_PAIRS; p++) begin : g_sb_pair
          localparam int unsigned BASE = ((r * C + c) * W + t) * CFG_TRK_BITS + p * CODE_W;
          localparam int unsigned FI   = node_side(r, c, pair_first(p), t);
          localparam int unsigned SI   = node_side(r, c, pair_second(p), t);
          assign seg[FI] = (brbselect[BASE +: CODE_W] == CODE_FWD) ? seg[SI] : 1'bz;
          assign seg[SI] = (brbselect[BASE +: CODE_W] == CODE_REV) ? seg[FI] : 1'bz;
        end
      end
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_io_lr
    for (genvar t = 0; t < W; t++) begin : g_trk
      localparam int unsigned B  = (r * W + t) * CODE_W;
      localparam int unsigned LI = hidx(r, 0, t);
      localparam int unsigned RI = hidx(r, C, t);
      assign seg[LI]  = (leftioselect[B +: CODE_W] == CODE_FWD) ? left[r] : 1'bz;
      assign left[r]  = (leftioselect[B +: CODE_W] == CODE_REV) ? seg[LI] : 1'bz;
      assign seg[RI]  = (rightioselect[B +: CODE_W] == CODE_FWD) ? right[r] : 1'bz;
      assign right[r] = (rightioselect[B +: CODE_W] == CODE_REV) ? seg[RI] : 1'bz;
    end
  end

  for (genvar c = 0; c < C; c++) begin : g_io_tb
    for (genvar t = 0; t < W; t++) begin : g_trk
      localparam int unsigned B  = (c * W + t) * CODE_W;
      localparam int unsigned BI = vidx(0, c, t);
      localparam int unsigned TI = vidx(R, c, t);
      assign seg[BI]    = (bottomioselect[B +: CODE_W] == CODE_FWD) ? bottom[c] : 1'bz;
      assign bottom[c]  = (bottomioselect[B +: CODE_W] == CODE_REV) ? seg[BI] : 1'bz;
      assign seg[TI]    = (topioselect[B +: CODE_W] == CODE_FWD) ? top[c] : 1'bz;
      assign top[c]     = (topioselect[B +: CODE_W] == CODE_REV) ? seg[TI] : 1'bz;
    end
  end

  for (genvar r = 0; r < R - 1; r++) begin : g_lb_row
    for (genvar c = 0; c < C - 1; c++) begin : g_lb_col
      localparam int unsigned CB = (r * (C - 1) + c) * LB_STRIDE;
      logic [LBS_USED*W-1:0] trk;
      logic [LBS_USED*W-1:0] a_en;
      logic [LBS_USED*W-1:0] b_en;
      logic                  a_in;
      logic                  b_in;
      logic                  y;

      for (genvar t = 0; t < W; t++) begin : g_trk
        for (genvar s = 0; s < LBS_USED; s++) begin : g_side
          localparam int unsigned IDX = lb_side(r, c, s, t);
          localparam int unsigned OFF = CB + t * CFG_TRK_BITS + s * CODE_W;
          localparam int unsigned K   = t * LBS_USED + s;
          assign trk[K]   = seg[IDX];
          assign a_en[K]  = (bsbselect[OFF + PIN_A*PIN_STRIDE +: CODE_W] == CODE_FWD);
          assign b_en[K]  = (bsbselect[OFF + PIN_B*PIN_STRIDE +: CODE_W] == CODE_FWD);
          assign seg[IDX] = (bsbselect[OFF + PIN_Y*PIN_STRIDE +: CODE_W] == CODE_REV) ? y : 1'bz;
        end
      end

      assign a_in = |(a_en & trk);
      assign b_in = |(b_en & trk);

      fpga_lb u_lb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .a_i    (a_in),
        .b_i    (b_in),
        .cfg_i  (lbselect[(r * (C - 1) + c) * LB_CFG_BITS +: LB_CFG_BITS]),
        .y_o    (y)
      );
    end
  end

endmodule

// File: tb/tb_fpga_top.sv
// Directed bench for fpga_top: pad pass-through, isolation, LUT routing, registered mode and reset.
module tb_fpga_top;

  localparam int unsigned W = 3;
  localparam int unsigned R = 5;
  localparam int unsigned C = 5;
  localparam logic [1:0] PZ = 2'd2;

  typedef enum int unsigned {S_ZERO, S_PASS, S_CODE11, S_AND, S_ANDN} scen_e;

  typedef struct {
    scen_e          scen;
    logic [C-1:0]   boe;
    logic [C-1:0]   bdv;
    logic [C-1:0]   toe;
    logic [C-1:0]   tdv;
    logic [1:0]     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [R*C*W*12-1:0]           brb;
  logic [(R-1)*(C-1)*W*W*12-1:0] bsb;
  logic [(R-1)*(C-1)*5-1:0]      lbs;
  logic [R*W*2-1:0]              lio, rio;
  logic [C*W*2-1:0]              tio, bio;
  tri   [R-1:0]                  left_w, right_w;
  tri   [C-1:0]                  top_w, bottom_w;
  logic [C-1:0]                  b_oe, b_dv, t_oe, t_dv;
  logic [R-1:0]                  lz, rz;
  logic [C-1:0]                  tz, bz;
  int unsigned                   n_chk = 0;
  int unsigned                   n_err = 0;
  vec_t                          vecs [16];

  always #5 clk = ~clk;

  for (genvar i = 0; i < C; i++) begin : g_cdrv
    assign bottom_w[i] = b_oe[i] ? b_dv[i] : 1'bz;
    assign top_w[i]    = t_oe[i] ? t_dv[i] : 1'bz;
    assign bz[i]       = (bottom_w[i] === 1'bz);
    assign tz[i]       = (top_w[i] === 1'bz);
  end
  for (genvar i = 0; i < R; i++) begin : g_robs
    assign lz[i] = (left_w[i] === 1'bz);
    assign rz[i] = (right_w[i] === 1'bz);
  end

  fpga_top #(.W(W), .R(R), .C(C)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .brbselect      (brb),
    .bsbselect      (bsb),
    .lbselect       (lbs),
    .leftioselect   (lio),
    .rightioselect  (rio),
    .topioselect    (tio),
    .bottomioselect (bio),
    .left           (left_w),
    .right          (right_w),
    .top            (top_w),
    .bottom         (bottom_w)
  );

  function automatic string cstr(input logic [1:0] v);
    if (v === 2'd0) return "0";
    if (v === 2'd1) return "1";
    if (v === PZ)   return "z";
    return "x";
  endfunction

  function automatic logic [1:0] l0_code();
    return lz[0] ? PZ : {1'b0, left_w[0]};
  endfunction

  // Pads that nobody in the bench drives and that are not the observed output.
  function automatic int unsigned other_active();
    int unsigned n = 0;
    for (int unsigned i = 1; i < R; i++) if (!lz[i]) n++;
    for (int unsigned i = 0; i < R; i++) if (!rz[i]) n++;
    for (int unsigned i = 0; i < C; i++) begin
      if (!t_oe[i] && !tz[i]) n++;
      if (!b_oe[i] && !bz[i]) n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: left[0] got %s expected %s", name, cstr(act), cstr(exp));
    end
  endtask

  task automatic chk_n(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: active pads got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input scen_e scen, input logic sync);
    brb = '0; bsb = '0; lbs = '0; lio = '0; rio = '0; tio = '0; bio = '0;
    case (scen)
      S_PASS, S_CODE11: begin
        bio[1:0] = 2'b01;
        brb[5:4] = (scen == S_PASS) ? 2'b01 : 2'b11;
        lio[1:0] = 2'b10;
      end
      S_AND, S_ANDN: begin
        bio[1:0]     = 2'b01;   // bottom[0] -> S of node(0,0) track 0
        brb[9:8]     = 2'b01;   // node(0,0) t0 E <- S
        bsb[1:0]     = 2'b01;   // LB(0,0) A <- side 0 t0
        bio[9:8]     = 2'b01;   // bottom[1] -> S of node(0,1) track 1
        brb[53:52]   = 2'b01;   // node(0,1) t1 W <- S
        bsb[49:48]   = 2'b01;   // LB(0,0) B <- side 0 t1
        bsb[103:102] = 2'b10;   // LB(0,0) Y -> side 3 t2
        brb[31:30]   = 2'b10;   // node(0,0) t2 W <- N
        lio[5:4]     = 2'b10;   // left edge t2 -> left[0]
        lbs[4:0]     = {sync, (scen == S_AND) ? 4'b1000 : 4'b0010};
      end
      default: ;
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{S_ZERO,   5'b11111, 5'b00000, 5'b00000, 5'b00000, PZ};
    vecs[1]  = '{S_ZERO,   5'b11111, 5'b10101, 5'b11111, 5'b01010, PZ};
    vecs[2]  = '{S_ZERO,   5'b00000, 5'b00000, 5'b11111, 5'b11111, PZ};
    vecs[3]  = '{S_PASS,   5'b00001, 5'b00000, 5'b00000, 5'b00000, 2'd0};
    vecs[4]  = '{S_PASS,   5'b00001, 5'b00001, 5'b00000, 5'b00000, 2'd1};
    vecs[5]  = '{S_PASS,   5'b00001, 5'b00000, 5'b00000, 5'b00000, 2'd0};
    vecs[6]  = '{S_CODE11, 5'b00001, 5'b00001, 5'b00000, 5'b00000, PZ};
    vecs[7]  = '{S_CODE11, 5'b00001, 5'b00000, 5'b00000, 5'b00000, PZ};
    vecs[8]  = '{S_AND,    5'b00011, 5'b00000, 5'b00000, 5'b00000, 2'd0};
    vecs[9]  = '{S_AND,    5'b00011, 5'b00001, 5'b00000, 5'b00000, 2'd0};
    vecs[10] = '{S_AND,    5'b00011, 5'b00010, 5'b00000, 5'b00000, 2'd0};
    vecs[11] = '{S_AND,    5'b00011, 5'b00011, 5'b00000, 5'b00000, 2'd1};
    vecs[12] = '{S_ANDN,   5'b00011, 5'b00001, 5'b00000, 5'b00000, 2'd1};
    vecs[13] = '{S_ANDN,   5'b00011, 5'b00010, 5'b00000, 5'b00000, 2'd0};
    vecs[14] = '{S_ANDN,   5'b00011, 5'b00011, 5'b00000, 5'b00000, 2'd0};
    vecs[15] = '{S_AND,    5'b00011, 5'b00011, 5'b00000, 5'b00000, 2'd1};

    rst_n = 1'b0;
    t_oe = '0; t_dv = '0;
    b_oe = 5'b00011; b_dv = 5'b00011;
    set_cfg(S_AND, 1'b1);
    #2;
    chk("reset_reg_clear", l0_code(), 2'd0);
    @(posedge clk); #1;
    chk("reset_holds_over_edge", l0_code(), 2'd0);
    set_cfg(S_AND, 1'b0);
    #1;
    chk("reset_comb_unaffected", l0_code(), 2'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 16; i++) begin
      set_cfg(vecs[i].scen, 1'b0);
      b_oe = vecs[i].boe; b_dv = vecs[i].bdv;
      t_oe = vecs[i].toe; t_dv = vecs[i].tdv;
      #2;
      chk($sformatf("vec%0d_left0", i), l0_code(), vecs[i].exp);
      chk_n($sformatf("vec%0d_others_z", i), other_active(), 0);
    end

    t_oe = '0;
    b_oe = 5'b00011; b_dv = 5'b00000;
    set_cfg(S_AND, 1'b1);
    @(posedge clk); #1;
    chk("reg_00", l0_code(), 2'd0);
    @(negedge clk);
    b_dv = 5'b00011;
    #1;
    chk("reg_hold_before_edge", l0_code(), 2'd0);
    @(posedge clk); #1;
    chk("reg_rise_at_edge", l0_code(), 2'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", l0_code(), 2'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_hold_after_release", l0_code(), 2'd0);
    @(posedge clk); #1;
    chk("rst_recover_at_edge", l0_code(), 2'd1);
    @(negedge clk);
    b_dv = 5'b00001;
    #1;
    chk("reg_hold_high", l0_code(), 2'd1);
    @(posedge clk); #1;
    chk("reg_fall_at_edge", l0_code(), 2'd0);
    chk_n("reg_others_z", other_active(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
